// File: rtl/hilo_div_ctrl_pkg.sv
// Shared definitions for the HI/LO divide sequencer: FSM encodings and
// handshake constants used by the controller and its environment.
package hilo_div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_DIVZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_READY     = 1'b1;
  localparam logic DIV_NOT_READY = 1'b0;
  localparam logic DIV_START     = 1'b1;
  localparam logic DIV_STOP      = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/hilo_div_ctrl_div_step.sv
// One restoring-division step: shift the {rem, quo} accumulator left, trial
// subtract the divisor from the upper W+1 bits, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] divisor,
  output logic [2*WIDTH:0] acc_nxt
);

  logic [2*WIDTH:0]        shifted;
  logic signed [WIDTH+1:0] diff;

  always_comb begin
    shifted = acc << 1;
    // One guard bit above the W+1-bit partial remainder carries the sign.
    diff    = $signed({1'b0, shifted[2*WIDTH:WIDTH]}) - $signed({2'b00, divisor});
    if (diff[WIDTH+1]) begin
      acc_nxt = shifted;
    end else begin
      acc_nxt = {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the EX-stage HI/LO path: one quotient bit
// per cycle, stalls the pipeline while running, presents {rem, quo} with ready.
module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_req
);

  localparam int                CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;

  logic [2*WIDTH:0] acc_p0;
  logic [2*WIDTH:0] acc_nxt;
  logic [WIDTH-1:0] divisor_p0;
  logic             sign_q_p0;
  logic             sign_r_p0;

  logic accept;
  logic run_step;
  logic load_res;
  logic clr_res;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic                    is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return -v;
    end
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? ((~v) + WIDTH'(1'b1)) : v;
  endfunction

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .acc     (acc_p0),
    .divisor (divisor_p0),
    .acc_nxt (acc_nxt)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    run_step  = 1'b0;
    load_res  = 1'b0;
    clr_res   = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start == DIV_START && !annul) begin
          accept    = 1'b1;
          state_nxt = (opdata2 == '0) ? DIV_DIVZERO : DIV_ON;
        end
      end
      DIV_DIVZERO: begin
        if (annul) begin
          state_nxt = DIV_IDLE;
        end else begin
          clr_res   = 1'b1;
          state_nxt = DIV_END;
        end
      end
      DIV_ON: begin
        if (annul) begin
          state_nxt = DIV_IDLE;
        end else begin
          run_step = 1'b1;
          if (cnt == LAST_STEP) begin
            load_res  = 1'b1;
            state_nxt = DIV_END;
          end
        end
      end
      DIV_END: begin
        if (annul || start == DIV_STOP) begin
          state_nxt = DIV_IDLE;
        end
      end
      default: state_nxt = DIV_IDLE;
    endcase
  end

  // Control and architecturally visible result: async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
      end else if (run_step) begin
        cnt <= cnt + CNT_W'(1'b1);
      end
      if (load_res) begin
        result <= {apply_sign(acc_nxt[2*WIDTH-1:WIDTH], sign_r_p0),
                   apply_sign(acc_nxt[WIDTH-1:0], sign_q_p0)};
      end else if (clr_res) begin
        result <= '0;
      end
    end
  end

  // Operand latch and accumulator: no reset, only consumed under FSM control.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_p0     <= {{(WIDTH + 1){1'b0}}, magnitude(opdata1, signed_div)};
      divisor_p0 <= magnitude(opdata2, signed_div);
      sign_q_p0  <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
      sign_r_p0  <= signed_div & opdata1[WIDTH-1];
    end else if (run_step) begin
      acc_p0 <= acc_nxt;
    end
  end

  assign ready     = (state == DIV_END) ? DIV_READY : DIV_NOT_READY;
  assign stall_req = !rst && start && !annul && (state != DIV_END);

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl: latency, signed/unsigned results,
// divide-by-zero, flush and asynchronous reset behaviour.
module tb_hilo_div_ctrl;
  import hilo_div_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  int n_vec;
  int n_err;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  hilo_div_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .start      (start),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  always #5 clk = ~clk;

  // Issue one request at posedge+1 and wait for ready; operands are scrambled
  // after acceptance. Returns cycles from acceptance to ready (-1 on timeout).
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat,
                         output logic stall_hi, output logic stall_rdy);
    signed_div = s;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    #1;
    stall_hi  = stall_req;
    stall_rdy = 1'b1;
    lat       = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #2;
      opdata1    = $urandom;
      opdata2    = $urandom;
      signed_div = ~s;
      if (ready) begin
        lat       = k;
        stall_rdy = stall_req;
        break;
      end
      if (!stall_req) stall_hi = 1'b0;
    end
    res   = result;
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start   = 1'b1;
    opdata1 = 32'd10;
    opdata2 = 32'd5;
    #12;
    n_vec++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_vec++;
    if (result !== 64'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
    n_vec++;
    if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL post_reset_ready: got %b want 0", ready); end
  endtask

  task automatic test_divu_basic();
    logic [63:0] res;
    int          lat;
    logic        shi, srdy;
    run_div(1'b0, 32'd100, 32'd7, res, lat, shi, srdy);
    n_vec++;
    if (lat !== 33) begin n_err++; $display("FAIL divu_latency: got %0d want 33", lat); end
    n_vec++;
    if (res !== 64'h00000002_0000000E) begin n_err++; $display("FAIL divu_100_7: got %h want 000000020000000e", res); end
    n_vec++;
    if (shi !== 1'b1) begin n_err++; $display("FAIL divu_stall_busy: got %b want 1", shi); end
    n_vec++;
    if (srdy !== 1'b0) begin n_err++; $display("FAIL divu_stall_ready: got %b want 0", srdy); end
  endtask

  task automatic test_divzero();
    logic [63:0] res;
    int          lat;
    logic        shi, srdy;
    run_div(1'b1, 32'd5, 32'd0, res, lat, shi, srdy);
    n_vec++;
    if (lat !== 2) begin n_err++; $display("FAIL divzero_latency: got %0d want 2", lat); end
    n_vec++;
    if (res !== 64'h0) begin n_err++; $display("FAIL divzero_result: got %h want 0", res); end
    n_vec++;
    if (shi !== 1'b1) begin n_err++; $display("FAIL divzero_stall_busy: got %b want 1", shi); end
    n_vec++;
    if (srdy !== 1'b0) begin n_err++; $display("FAIL divzero_stall_ready: got %b want 0", srdy); end
  endtask

  task automatic test_signed();
    vec_t        tbl[5];
    logic [63:0] res;
    int          lat;
    logic        shi, srdy;
    tbl[0] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD};
    tbl[1] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
    tbl[2] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003};
    tbl[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
    tbl[4] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      run_div(tbl[i].s, tbl[i].a, tbl[i].b, res, lat, shi, srdy);
      n_vec++;
      if (res !== tbl[i].exp) begin
        n_err++;
        $display("FAIL div_vec%0d: got %h want %h", i, res, tbl[i].exp);
      end
      n_vec++;
      if (lat !== 33) begin n_err++; $display("FAIL div_vec%0d_latency: got %0d want 33", i, lat); end
    end
  endtask

  task automatic test_annul();
    logic saw_rdy;
    int   lat;
    saw_rdy    = 1'b0;
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd10;
    start      = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #2;
      if (ready) saw_rdy = 1'b1;
    end
    annul = 1'b1;
    #1;
    n_vec++;
    if (stall_req !== 1'b0) begin n_err++; $display("FAIL annul_stall: got %b want 0", stall_req); end
    @(posedge clk);
    #2;
    if (ready) saw_rdy = 1'b1;
    annul   = 1'b0;
    opdata1 = 32'd12345;
    opdata2 = 32'd100;
    #1;
    n_vec++;
    if (saw_rdy !== 1'b0) begin n_err++; $display("FAIL annul_ready: got %b want 0", saw_rdy); end
    n_vec++;
    if (result !== 64'h00000000_FFFFFFFF) begin n_err++; $display("FAIL annul_result_kept: got %h want 00000000ffffffff", result); end
    n_vec++;
    if (stall_req !== 1'b1) begin n_err++; $display("FAIL annul_idle_stall: got %b want 1", stall_req); end
    lat = -1;
    for (int k = 12; k <= 120; k++) begin
      @(posedge clk);
      #2;
      if (ready) begin
        lat = k;
        break;
      end
    end
    n_vec++;
    if (lat !== 44) begin n_err++; $display("FAIL restart_cycle: got %0d want 44", lat); end
    n_vec++;
    if (result !== {32'd45, 32'd123}) begin n_err++; $display("FAIL restart_result: got %h want 0000002d0000007b", result); end
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    logic [63:0] res;
    int          lat;
    logic        shi, srdy;
    signed_div = 1'b0;
    opdata1    = 32'd500;
    opdata2    = 32'd3;
    start      = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #2;
    end
    #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL arst_ready: got %b want 0", ready); end
    n_vec++;
    if (result !== 64'h0) begin n_err++; $display("FAIL arst_result: got %h want 0", result); end
    n_vec++;
    if (stall_req !== 1'b0) begin n_err++; $display("FAIL arst_stall: got %b want 0", stall_req); end
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_div(1'b0, 32'd9, 32'd3, res, lat, shi, srdy);
    n_vec++;
    if (res !== 64'h00000000_00000003) begin n_err++; $display("FAIL arst_divu_9_3: got %h want 0000000000000003", res); end
    n_vec++;
    if (lat !== 33) begin n_err++; $display("FAIL arst_divu_latency: got %0d want 33", lat); end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    clk        = 1'b0;
    rst        = 1'b1;
    start      = DIV_STOP;
    annul      = 1'b0;
    signed_div = 1'b0;
    opdata1    = ZERO_WORD;
    opdata2    = ZERO_WORD;
    test_reset();
    test_divu_basic();
    test_divzero();
    test_signed();
    test_annul();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
